// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, decode FSM states and the field decoder.
// Pure combinational helpers; no latency, no flow control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {IDLE, CHECK, READ, OUT} state_t;

  typedef struct packed {
    logic        illegal;
    logic        use_rs;
    logic        use_rt;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t        d;
    logic [31:0] sext;
    logic [31:0] zext;
    sext = {{16{instr[15]}}, instr[15:0]};
    zext = {16'h0000, instr[15:0]};
    d = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.wnum   = instr[15:11];
        d.wen    = (instr[5:0] != FUNCT_JR);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.use_rs = 1'b1;
        d.wnum   = instr[20:16];
        d.wen    = 1'b1;
        d.imm    = sext;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.use_rs = 1'b1;
        d.wnum   = instr[20:16];
        d.wen    = 1'b1;
        d.imm    = zext;
      end
      OP_LUI: begin
        d.wnum = instr[20:16];
        d.wen  = 1'b1;
        d.imm  = {instr[15:0], 16'h0000};
      end
      OP_LW: begin
        d.use_rs = 1'b1;
        d.wnum   = instr[20:16];
        d.wen    = 1'b1;
        d.imm    = sext;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.imm    = sext;
      end
      OP_J: ;
      OP_JAL: begin
        d.wnum = REG_RA;
        d.wen  = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // $zero is hardwired, so a write to it is never a real write.
    if (d.wnum == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared by writeback.
// One-cycle update; queries read the registered bits. Set beats clear on the same register.
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_num,
  input  logic       clr_en,
  input  logic [4:0] clr_num,
  input  logic [4:0] a_num,
  input  logic [4:0] b_num,
  output logic       busy_a,
  output logic       busy_b
);

  logic [31:0] busy_q;
  logic [31:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_num] = 1'b0;
    if (set_en) busy_nxt[set_num] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy_a = busy_q[a_num] && (a_num != 5'd0);
  assign busy_b = busy_q[b_num] && (b_num != 5'd0);

endmodule

// File: rtl/instr_decode.sv
// MIPS decode stage: accept -> hazard check -> regfile read -> present; 2+READ_LAT cycles without hazard.
// Output held until out_ready; in_ready follows out_ready in OUT. DECODE_STALL_STATS_EN adds stall/instr counters.
module instr_decode
  import mips_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rnum1,
  output logic [4:0]  rnum2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_shamt,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val,
  output logic [31:0] out_imm,
  output logic [25:0] out_target,
  output logic [4:0]  out_wnum,
  output logic        out_wen,
  output logic        out_illegal
`ifdef DECODE_STALL_STATS_EN
  , output logic [31:0] stall_cycles
  , output logic [31:0] instr_count
`endif
);

  localparam int CNT_W = 2;

  state_t           state, state_nxt;
  logic [31:0]      instr_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  dec_t             dec;
  logic             busy_a, busy_b;
  logic             hazard;
  logic             accept;
  logic             capture;
  logic             set_en;

  assign dec    = decode(instr_q);
  assign rnum1  = instr_q[25:21];
  assign rnum2  = instr_q[20:16];
  assign hazard = (dec.use_rs && busy_a) || (dec.use_rt && busy_b);
  assign accept = in_valid && in_ready;
  assign set_en = capture && dec.wen;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CHECK;
      end
      CHECK: if (!hazard) state_nxt = READ;
      READ: begin
        if (cnt_q == '0) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? CHECK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct   <= '0;
      out_shamt   <= '0;
      out_rs_val  <= '0;
      out_rt_val  <= '0;
      out_imm     <= '0;
      out_target  <= '0;
      out_wnum    <= '0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
      end
      if (state == CHECK && !hazard)
        cnt_q <= CNT_W'(READ_LAT - 1);
      else if (state == READ && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (capture) begin
        out_pc      <= pc_q;
        out_opcode  <= instr_q[31:26];
        out_funct   <= instr_q[5:0];
        out_shamt   <= instr_q[10:6];
        out_rs_val  <= rdata1;
        out_rt_val  <= rdata2;
        out_imm     <= dec.imm;
        out_target  <= instr_q[25:0];
        out_wnum    <= dec.wnum;
        out_wen     <= dec.wen;
        out_illegal <= dec.illegal;
      end
    end
  end

  reg_scoreboard u_sb (
    .clock   (clock),
    .reset   (reset),
    .set_en  (set_en),
    .set_num (dec.wnum),
    .clr_en  (wb_valid),
    .clr_num (wb_num),
    .a_num   (rnum1),
    .b_num   (rnum2),
    .busy_a  (busy_a),
    .busy_b  (busy_b)
  );

`ifdef DECODE_STALL_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      instr_count  <= '0;
    end else begin
      if (state == CHECK && hazard && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (out_valid && out_ready)
        instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with a one-cycle registered register-file model.
module tb_instr_decode;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rnum1, rnum2;
  logic [31:0] rdata1, rdata2;
  logic        wb_valid;
  logic [4:0]  wb_num;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_shamt;
  logic [31:0] out_rs_val;
  logic [31:0] out_rt_val;
  logic [31:0] out_imm;
  logic [25:0] out_target;
  logic [4:0]  out_wnum;
  logic        out_wen;
  logic        out_illegal;
`ifdef DECODE_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] rf [32];

  instr_decode #(.READ_LAT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rnum1       (rnum1),
    .rnum2       (rnum2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .wb_valid    (wb_valid),
    .wb_num      (wb_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_funct   (out_funct),
    .out_shamt   (out_shamt),
    .out_rs_val  (out_rs_val),
    .out_rt_val  (out_rt_val),
    .out_imm     (out_imm),
    .out_target  (out_target),
    .out_wnum    (out_wnum),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
`ifdef DECODE_STALL_STATS_EN
    , .stall_cycles (stall_cycles)
    , .instr_count  (instr_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rdata1 <= rf[rnum1];
    rdata2 <= rf[rnum2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one instruction from IDLE and returns cycles from the accept cycle to out_valid.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, output int n_lat);
    int n;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n_lat = 1;
    while (!out_valid && n_lat < 50) begin
      tick();
      n_lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] num);
    wb_valid = 1'b1;
    wb_num   = num;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_num    = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h0;
    rf[9] = 32'd10;
    tick();
    tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_wen", out_wen, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_busy", dut.u_sb.busy_q, 0);
    check("rst_state", dut.state, IDLE);
    reset = 1'b0;
    tick();

    // addi $t0,$t1,-4
    issue(32'h2128FFFC, 32'h400, lat);
    check("addi_latency", lat, 3);
    check("addi_rs_val", out_rs_val, 32'd10);
    check("addi_imm", out_imm, 32'hFFFFFFFC);
    check("addi_wnum", out_wnum, 8);
    check("addi_wen", out_wen, 1);
    check("addi_pc", out_pc, 32'h400);
    check("addi_opcode", out_opcode, 6'h08);
    check("addi_busy8", dut.u_sb.busy_q[8], 1);

    // Backpressure: add is offered but out_ready stays low for 4 cycles.
    in_valid = 1'b1;
    in_instr = 32'h01085020;
    in_pc    = 32'h404;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_imm", out_imm, 32'hFFFFFFFC);
      check("hold_rs_val", out_rs_val, 32'd10);
      check("hold_wnum", out_wnum, 8);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_state", dut.state, CHECK);
    check("b2b_out_valid", out_valid, 0);

    // add $t2,$t0,$t0 waits on busy $t0
    for (int i = 0; i < 3; i++) begin
      tick();
      check("raw_stall_state", dut.state, CHECK);
      check("raw_stall_valid", out_valid, 0);
    end
    wb_pulse(5'd8);
    check("wb_same_cycle_state", dut.state, CHECK);
    check("wb_busy8_clear", dut.u_sb.busy_q[8], 0);
    tick();
    check("wb_next_state", dut.state, READ);
    tick();
    check("add_out_valid", out_valid, 1);
    check("add_rs_val", out_rs_val, 32'h108);
    check("add_rt_val", out_rt_val, 32'h108);
    check("add_wnum", out_wnum, 10);
    check("add_wen", out_wen, 1);
    check("add_funct", out_funct, 6'h20);
    check("add_opcode", out_opcode, 6'h00);
    consume();
    wb_pulse(5'd10);

    // ori $t3,$zero,0x8000
    issue(32'h340B8000, 32'h408, lat);
    check("ori_latency", lat, 3);
    check("ori_imm", out_imm, 32'h00008000);
    check("ori_wnum", out_wnum, 11);
    check("ori_wen", out_wen, 1);
    consume();

    // lui $t4,0x1234
    issue(32'h3C0C1234, 32'h40C, lat);
    check("lui_imm", out_imm, 32'h12340000);
    check("lui_wnum", out_wnum, 12);
    check("lui_wen", out_wen, 1);
    consume();

    // sw $t5,4($sp)
    issue(32'hAFAD0004, 32'h410, lat);
    check("sw_latency", lat, 3);
    check("sw_wen", out_wen, 0);
    check("sw_imm", out_imm, 32'h4);
    check("sw_rs_val", out_rs_val, 32'h11D);
    check("sw_rt_val", out_rt_val, 32'h10D);
    consume();

    // jal 0x0100000
    issue(32'h0C100000, 32'h414, lat);
    check("jal_wnum", out_wnum, 31);
    check("jal_wen", out_wen, 1);
    check("jal_target", out_target, 26'h0100000);
    check("jal_busy31", dut.u_sb.busy_q[31], 1);
    consume();

    // opcode 0x3F
    issue(32'hFC000000, 32'h418, lat);
    check("ill_flag", out_illegal, 1);
    check("ill_wen", out_wen, 0);
    check("ill_busy", dut.u_sb.busy_q, 32'h80001800);
    consume();

    // addi $zero,$t1,5
    issue(32'h21200005, 32'h41C, lat);
    check("zero_wen", out_wen, 0);
    check("zero_illegal", out_illegal, 0);
    check("zero_busy0", dut.u_sb.busy_q[0], 0);
    check("zero_busy", dut.u_sb.busy_q, 32'h80001800);
    consume();

    // addi $t1,$zero,7 with a writeback of $t1 on the capture edge
    in_valid = 1'b1;
    in_instr = 32'h20090007;
    in_pc    = 32'h420;
    tick();
    in_valid = 1'b0;
    tick();
    check("setclr_state", dut.state, READ);
    wb_valid = 1'b1;
    wb_num   = 5'd9;
    tick();
    wb_valid = 1'b0;
    check("setclr_out_valid", out_valid, 1);
    check("setclr_busy9", dut.u_sb.busy_q[9], 1);
    check("setclr_imm", out_imm, 32'h7);
    consume();
`ifdef DECODE_STALL_STATS_EN
    check("stats_instr_count", instr_count, 9);
    check("stats_stall_cycles", stall_cycles, 4);
`endif

    // Reset while in READ
    in_valid = 1'b1;
    in_instr = 32'h340B8000;
    in_pc    = 32'h424;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst_pre_state", dut.state, READ);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", dut.u_sb.busy_q, 0);
    check("midrst_state", dut.state, IDLE);
    tick();
    reset = 1'b0;
    #1;
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    check("postrst_out_wen", out_wen, 0);
    check("postrst_out_imm", out_imm, 0);
`ifdef DECODE_STALL_STATS_EN
    check("postrst_instr_count", instr_count, 0);
    check("postrst_stall_cycles", stall_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
